param_reg_file: RTL and testbench

//  Parametrised multi-port register file: DEPTH rows x WIDTH bits, NRD synchronous read ports, one write port.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_row.sv | 30 +++
 rtl/param_reg_file.sv | 143 ++++++++++++++
 tb/tb_param_reg_file.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file.
//   rf_state_e : soft-clear sequencer states (idle / sweeping)
//   rf_aw      : address width for a given row count
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Address width for DEPTH rows; DEPTH is a power of two >= 2.
  function automatic int rf_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_row.sv
// One storage row of the register file.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears the row
//   we   : write enable, loads d
//   clr  : synchronous clear, wins over we
//   d    : write data
//   q    : stored value
module rf_row #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: DEPTH rows x WIDTH bits, NRD registered read
// ports, one write port, write-to-read bypass, optional hardwired-zero row 0
// and a soft-clear sweep that zeroes one row per cycle.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   wr_en     : write strobe (ignored during a clear sweep)
//   wr_addr   : write row
//   wr_data   : write data
//   rd_en     : per-port read enable
//   rd_addr   : packed read addresses, port p at [p*AW +: AW]
//   rd_data   : packed registered read data, port p at [p*WIDTH +: WIDTH]
//   rd_valid  : per-port data valid
//   clr_req   : pulse to start a clear sweep (ignored while sweeping)
//   clr_busy  : high while the sweep runs (exactly DEPTH cycles)
//   clr_state : current sweep-sequencer state, for observation
//
// Handshake: there is no back-pressure. A read accepted with rd_en[p]=1 at a
// clock edge produces rd_valid[p]=1 with its data for exactly the following
// cycle; rd_data[p] holds its last value when no read was accepted.
module param_reg_file
  import rf_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = rf_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output rf_state_e            clr_state
);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              wr_fire;
  logic [WIDTH-1:0]  rows [DEPTH];

  assign clr_busy  = (state_q == RF_CLEAR);
  assign clr_state = state_q;

  // A write only takes effect outside a sweep and never to a hardwired row 0.
  // The same qualified strobe drives the bypass, so dropped writes never bypass.
  assign wr_fire = wr_en && !clr_busy && !((ZERO_R0 != 0) && (wr_addr == '0));

  // ---------------- storage ----------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
      assign rows[i] = '0;
    end else begin : g_reg
      rf_row #(.WIDTH(WIDTH)) u_row (
        .clk (clk),
        .rst (rst),
        .we  (wr_fire && (wr_addr == AW'(i))),
        .clr (clr_busy && (ptr_q == AW'(i))),
        .d   (wr_data),
        .q   (rows[i])
      );
    end
  end

  // ---------------- read ports ----------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign ra = rd_addr[p*AW +: AW];

    // Hardwired zero beats bypass, bypass beats stored contents.
    always_comb begin
      rv = rows[ra];
      if (wr_fire && (wr_addr == ra)) begin
        rv = wr_data;
      end
      if ((ZERO_R0 != 0) && (ra == '0)) begin
        rv = '0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[p];
        if (rd_en[p]) begin
          data_q <= rv;
        end
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = data_q;
    assign rd_valid[p]               = valid_q;
  end

  // ---------------- soft-clear sequencer ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file (WIDTH=16, DEPTH=16, NRD=2, ZERO_R0=1).
module tb_param_reg_file;
  import rf_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic        clr_req;
  logic        clr_busy;
  rf_state_e   clr_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] e0, e1;

  param_reg_file #(
    .WIDTH(16), .DEPTH(16), .NRD(2), .ZERO_R0(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_state (clr_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fill(input int i);
    return 16'hA000 + 16'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; expected read data is queued when issued.
  task automatic op(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                    input logic [1:0] re, input logic [3:0] a0, input logic [15:0] x0,
                    input logic [3:0] a1, input logic [15:0] x1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    if (re[0]) exp_q0.push_back(x0);
    if (re[1]) exp_q1.push_back(x1);
    step();
    wr_en = 1'b0;
    rd_en = 2'b00;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 4'd0, 16'h0, 2'b11, 4'(i), 16'h0000, 4'(15 - i), 16'h0000);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (rd_valid[0]) begin
        if (exp_q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL port0_unexpected actual=%h expected=none", rd_data[15:0]);
        end else begin
          e0 = exp_q0.pop_front();
          check16("port0_data", rd_data[15:0], e0);
        end
      end
      if (rd_valid[1]) begin
        if (exp_q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL port1_unexpected actual=%h expected=none", rd_data[31:16]);
        end else begin
          e1 = exp_q1.pop_front();
          check16("port1_data", rd_data[31:16], e1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    int guard;

    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    clr_req = 1'b0;

    // Reset state
    repeat (3) step();
    check16("reset_rd_valid", {14'h0, rd_valid}, 16'h0000);
    check16("reset_rd_data0", rd_data[15:0], 16'h0000);
    check16("reset_rd_data1", rd_data[31:16], 16'h0000);
    check16("reset_clr_busy", {15'h0, clr_busy}, 16'h0000);
    check16("reset_state", {15'h0, clr_state}, {15'h0, RF_IDLE});
    rst = 1'b1;
    step();

    // 1: all rows read zero after reset on both ports
    read_all_zero();

    // 2: write then read on both ports
    op(1'b1, 4'd5, 16'hBEEF, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
    op(1'b0, 4'd0, 16'h0, 2'b11, 4'd5, 16'hBEEF, 4'd5, 16'hBEEF);

    // 3: same-cycle write/read bypass on port1, port0 reads an old row
    op(1'b1, 4'd3, 16'h1234, 2'b11, 4'd5, 16'hBEEF, 4'd3, 16'h1234);
    op(1'b0, 4'd0, 16'h0, 2'b11, 4'd3, 16'h1234, 4'd3, 16'h1234);

    // 4: hardwired row 0, same cycle and next cycle
    op(1'b1, 4'd0, 16'hFFFF, 2'b11, 4'd0, 16'h0000, 4'd5, 16'hBEEF);
    op(1'b0, 4'd0, 16'h0, 2'b11, 4'd0, 16'h0000, 4'd0, 16'h0000);

    // 5: fill, sweep, dropped write, ignored clr_req, all zero afterwards
    for (int i = 1; i < 16; i++) op(1'b1, 4'(i), fill(i), 2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
    op(1'b0, 4'd0, 16'h0, 2'b11, 4'd1, fill(1), 4'd15, fill(15));
    pulse_clr();
    busy_cnt = 0;
    guard    = 0;
    while (clr_busy && guard < 40) begin
      busy_cnt++;
      wr_en   = 1'b0;
      rd_en   = 2'b00;
      clr_req = 1'b0;
      if (busy_cnt == 2) begin
        // Row 15 not yet cleared; write is dropped and must not bypass.
        wr_en   = 1'b1;
        wr_addr = 4'd15;
        wr_data = 16'h5555;
        rd_en   = 2'b11;
        rd_addr = {4'd0, 4'd15};
        exp_q0.push_back(fill(15));
        exp_q1.push_back(16'h0000);
      end else if (busy_cnt == 5) begin
        clr_req = 1'b1;
      end
      step();
      guard++;
    end
    wr_en   = 1'b0;
    rd_en   = 2'b00;
    clr_req = 1'b0;
    check16("sweep_cycles", 16'(busy_cnt), 16'd16);
    check16("sweep_end_state", {15'h0, clr_state}, {15'h0, RF_IDLE});
    read_all_zero();

    // 6: reset in the middle of a sweep
    for (int i = 1; i < 16; i++) op(1'b1, 4'(i), fill(i), 2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
    pulse_clr();
    repeat (6) step();
    // Row 3 already cleared, row 12 not yet.
    op(1'b0, 4'd0, 16'h0, 2'b11, 4'd12, fill(12), 4'd3, 16'h0000);
    check16("busy_mid_sweep", {15'h0, clr_busy}, 16'h0001);
    check16("valid_before_rst", {14'h0, rd_valid}, 16'h0003);
    #5;
    rst = 1'b0;
    #1;
    check16("abort_clr_busy", {15'h0, clr_busy}, 16'h0000);
    check16("abort_rd_valid", {14'h0, rd_valid}, 16'h0000);
    check16("abort_rd_data0", rd_data[15:0], 16'h0000);
    check16("abort_rd_data1", rd_data[31:16], 16'h0000);
    repeat (2) step();
    rst = 1'b1;
    step();
    check16("abort_state", {15'h0, clr_state}, {15'h0, RF_IDLE});
    read_all_zero();

    repeat (3) step();
    check16("q0_drained", 16'(exp_q0.size()), 16'd0);
    check16("q1_drained", 16'(exp_q1.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
